// File: rtl/ker_sched_pkg.sv
// Shared definitions for the kernel bank ping-pong scheduler.
// Holds the write-FSM state encodings and the default group-count width.
// No logic; imported by the interface and the scheduler.
package ker_sched_pkg;

    localparam int GRP_BITS_DEF = 8;

    // Write FSM encodings (2-bit, legacy-compatible constants)
    localparam logic [1:0] WS_IDLE  = 2'd0;
    localparam logic [1:0] WS_WAIT  = 2'd1;
    localparam logic [1:0] WS_START = 2'd2;
    localparam logic [1:0] WS_RUN   = 2'd3;

endpackage

// File: rtl/ker_bank_sched_if.sv
// Handshake bundle between layer controller / write engine / PE array and the scheduler.
// master = scheduler side (drives start, bank selects, status); slave = environment side.
// Pure wiring, no latency; flow control is the start/busy/done level handshake.
interface ker_bank_sched_if
    import ker_sched_pkg::*;
#(
    parameter int GRP_BITS = GRP_BITS_DEF
);
    logic                layer_start;
    logic [GRP_BITS-1:0] cfg_grp_num;
    logic                start_ker_write;
    logic                ker_write_busy;
    logic                ker_write_done;
    logic                wr_bank_sel;
    logic                ker_bank_sel;
    logic                ker_bank_valid;
    logic                comp_done;
    logic                sched_busy;
    logic                layer_done;

    modport master (
        input  layer_start, cfg_grp_num, ker_write_busy, ker_write_done, comp_done,
        output start_ker_write, wr_bank_sel, ker_bank_sel, ker_bank_valid,
               sched_busy, layer_done
    );

    modport slave (
        output layer_start, cfg_grp_num, ker_write_busy, ker_write_done, comp_done,
        input  start_ker_write, wr_bank_sel, ker_bank_sel, ker_bank_valid,
               sched_busy, layer_done
    );
endinterface

// File: rtl/ker_bank_sched.sv
// Ping-pong scheduler for the two kernel SRAM banks: loads group g+1 while group g is consumed.
// Latency: start_ker_write rises two edges after an accepted layer_start; layer_done one edge after last comp_done.
// Backpressure: a write start waits for a free bank and an idle engine; start is held until busy is seen.
// Ports: clk, reset (async active-low), bus (ker_bank_sched_if.master) carrying the layer,
// write-engine and PE handshakes plus the wr/rd bank selects.
module ker_bank_sched
    import ker_sched_pkg::*;
#(
    parameter int GRP_BITS = GRP_BITS_DEF
)(
    input  logic              clk,
    input  logic              reset,
    ker_bank_sched_if.master  bus
);

    logic [1:0]          ws;
    logic [1:0]          bank_full;
    logic [1:0]          bank_nxt;
    logic                wr_ptr;
    logic                rd_ptr;
    logic [GRP_BITS-1:0] wr_cnt;
    logic [GRP_BITS-1:0] rd_cnt;
    logic [GRP_BITS-1:0] rd_cnt_nxt;
    logic [GRP_BITS-1:0] grp_num;
    logic                sched_busy;
    logic                layer_done;

    logic                accept;
    logic                rd_fire;
    logic                wr_fire;
    logic                finish;
    logic                bank_valid;

    assign accept     = bus.layer_start & ~sched_busy;
    assign bank_valid = sched_busy & bank_full[rd_ptr];
    assign rd_fire    = bus.comp_done & bank_valid;
    assign wr_fire    = (ws == WS_RUN) & bus.ker_write_done;
    assign rd_cnt_nxt = rd_cnt + {{(GRP_BITS-1){1'b0}}, rd_fire};

    // Looks at the post-update read count so layer_done lands one edge after the
    // final comp_done; with zero groups this fires on the first busy cycle.
    assign finish = sched_busy & (rd_cnt_nxt == grp_num);

    // A write completion and a consume in the same cycle always touch opposite
    // banks (a bank is written only while empty, read only while full).
    always_comb begin
        bank_nxt = bank_full;
        if (wr_fire) bank_nxt[wr_ptr] = 1'b1;
        if (rd_fire) bank_nxt[rd_ptr] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ws         <= WS_IDLE;
            bank_full  <= 2'b00;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            grp_num    <= '0;
            sched_busy <= 1'b0;
            layer_done <= 1'b0;
        end else begin
            layer_done <= finish;
            if (accept) begin
                grp_num    <= bus.cfg_grp_num;
                wr_cnt     <= '0;
                rd_cnt     <= '0;
                wr_ptr     <= 1'b0;
                rd_ptr     <= 1'b0;
                bank_full  <= 2'b00;
                sched_busy <= 1'b1;
                ws         <= WS_WAIT;
            end else if (sched_busy) begin
                bank_full <= bank_nxt;
                if (rd_fire) begin
                    rd_ptr <= ~rd_ptr;
                    rd_cnt <= rd_cnt_nxt;
                end
                if (wr_fire) begin
                    wr_ptr <= ~wr_ptr;
                    wr_cnt <= wr_cnt + 1'b1;
                end
                case (ws)
                    WS_WAIT: begin
                        // Engine must also be idle: it may keep busy high for a
                        // few recovery cycles after its done pulse.
                        if ((wr_cnt != grp_num) && !bank_full[wr_ptr] && !bus.ker_write_busy)
                            ws <= WS_START;
                    end
                    WS_START: begin
                        if (bus.ker_write_busy) ws <= WS_RUN;
                    end
                    WS_RUN: begin
                        if (bus.ker_write_done) ws <= WS_WAIT;
                    end
                    default: ws <= ws;
                endcase
                if (finish) begin
                    sched_busy <= 1'b0;
                    ws         <= WS_IDLE;
                end
            end
        end
    end

    assign bus.start_ker_write = (ws == WS_START);
    assign bus.wr_bank_sel     = wr_ptr;
    assign bus.ker_bank_sel    = rd_ptr;
    assign bus.ker_bank_valid  = bank_valid;
    assign bus.sched_busy      = sched_busy;
    assign bus.layer_done      = layer_done;

endmodule

// File: tb/tb_ker_bank_sched.sv
// Directed bench for ker_bank_sched with optional write-engine and PE behavioural models.
module tb_ker_bank_sched;

    logic clk;
    logic rst_n;

    ker_bank_sched_if #(.GRP_BITS(8)) bus ();

    ker_bank_sched #(.GRP_BITS(8)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // model controls
    bit eng_en = 0;
    bit pe_en  = 0;
    int eng_lat = 5;
    int comp_lat = 3;

    // monitor records
    int start_cnt = 0;
    logic start_bank [8];
    int start_cyc [8];
    int comp_cnt = 0;
    int comp_cyc [8];
    int last_comp_cyc = -1;
    int ld_cyc = -1;
    int ld_cnt = 0;
    int vld_cnt = 0;
    logic vld_bank = 1'b0;
    logic start_q = 1'b0;
    logic vld_q = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_rec();
        start_cnt = 0; comp_cnt = 0; last_comp_cyc = -1;
        ld_cyc = -1; ld_cnt = 0; vld_cnt = 0;
    endtask

    task automatic start_layer(input logic [7:0] n);
        bus.cfg_grp_num = n;
        bus.layer_start = 1'b1;
        tick();
        bus.layer_start = 1'b0;
        bus.cfg_grp_num = 8'd0;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (!bus.start_ker_write && n < 50) begin tick(); n++; end
        check(tag, 32'(bus.start_ker_write), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!bus.layer_done && n < budget) begin tick(); n++; end
        check(tag, 32'(bus.layer_done), 32'd1);
    endtask

    task automatic pulse_done();
        bus.ker_write_done = 1'b1;
        tick();
        bus.ker_write_done = 1'b0;
        bus.ker_write_busy = 1'b0;
    endtask

    task automatic pulse_comp();
        bus.comp_done = 1'b1;
        tick();
        bus.comp_done = 1'b0;
    endtask

    function automatic logic [5:0] outs();
        return {bus.start_ker_write, bus.wr_bank_sel, bus.ker_bank_sel,
                bus.ker_bank_valid, bus.sched_busy, bus.layer_done};
    endfunction

    initial forever @(posedge clk) cyc++;

    // monitor
    initial forever begin
        @(negedge clk);
        if (bus.start_ker_write && !start_q) begin
            if (start_cnt < 8) begin
                start_bank[start_cnt] = bus.wr_bank_sel;
                start_cyc[start_cnt]  = cyc;
            end
            start_cnt++;
        end
        start_q = bus.start_ker_write;
        if (bus.ker_bank_valid && !vld_q) begin
            vld_bank = bus.ker_bank_sel;
            vld_cnt++;
        end
        vld_q = bus.ker_bank_valid;
        if (bus.layer_done) begin
            ld_cyc = cyc;
            ld_cnt++;
        end
    end

    // write engine model: acknowledges start, done after eng_lat cycles
    initial forever begin
        @(negedge clk);
        if (eng_en && bus.start_ker_write && !bus.ker_write_busy) begin
            bus.ker_write_busy = 1'b1;
            repeat (eng_lat) @(negedge clk);
            bus.ker_write_done = 1'b1;
            @(negedge clk);
            bus.ker_write_done = 1'b0;
            bus.ker_write_busy = 1'b0;
        end
    end

    // PE model: consumes a valid bank after comp_lat cycles
    initial forever begin
        @(negedge clk);
        if (pe_en && bus.ker_bank_valid) begin
            repeat (comp_lat) @(negedge clk);
            bus.comp_done = 1'b1;
            @(negedge clk);
            bus.comp_done = 1'b0;
            if (comp_cnt < 8) comp_cyc[comp_cnt] = cyc;
            last_comp_cyc = cyc;
            comp_cnt++;
        end
    end

    initial begin
        bus.layer_start    = 1'b0;
        bus.cfg_grp_num    = 8'd0;
        bus.ker_write_busy = 1'b0;
        bus.ker_write_done = 1'b0;
        bus.comp_done      = 1'b0;
        rst_n = 1'b0;
        tick(2);
        check("reset_outputs", 32'(outs()), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // ---- reset mid-layer (write engine running)
        start_layer(8'd1);
        wait_start("rst_start");
        bus.ker_write_busy = 1'b1;
        tick(3);
        check("rst_pre_busy", 32'(bus.sched_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("rst_async_outs", 32'(outs()), 32'd0);
        bus.ker_write_busy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        start_layer(8'd1);
        check("rst_reaccept_busy", 32'(bus.sched_busy), 32'd1);
        wait_start("rst_reaccept_start");
        bus.ker_write_busy = 1'b1;
        tick();
        pulse_done();
        check("rst_valid", 32'(bus.ker_bank_valid), 32'd1);
        pulse_comp();
        check("rst_layer_done", 32'(bus.layer_done), 32'd1);
        tick(2);

        // ---- one group, slow engine
        clear_rec();
        eng_lat = 300; comp_lat = 20; eng_en = 1; pe_en = 1;
        start_layer(8'd1);
        check("g1_busy_after_accept", 32'({bus.sched_busy, bus.start_ker_write}), 32'b10);
        wait_done("g1_layer_done", 1000);
        tick();
        check("g1_starts", 32'(start_cnt), 32'd1);
        check("g1_start_bank", 32'(start_bank[0]), 32'd0);
        check("g1_valid_bank", 32'({vld_cnt[3:0], vld_bank}), {27'd0, 4'd1, 1'b0});
        check("g1_done_lag", 32'(ld_cyc - last_comp_cyc), 32'd0);
        check("g1_done_width", 32'(ld_cnt), 32'd1);
        check("g1_idle", 32'(bus.sched_busy), 32'd0);

        // ---- four groups, slow compute
        clear_rec();
        eng_lat = 50; comp_lat = 1000;
        start_layer(8'd4);
        wait_done("g4_layer_done", 6000);
        tick();
        check("g4_starts", 32'(start_cnt), 32'd4);
        check("g4_start_banks", 32'({start_bank[3], start_bank[2], start_bank[1], start_bank[0]}), 32'b1010);
        check("g4_third_start_held", 32'(start_cyc[2] - comp_cyc[0]), 32'd1);
        check("g4_comps", 32'(comp_cnt), 32'd4);
        check("g4_done_lag", 32'(ld_cyc - last_comp_cyc), 32'd0);
        eng_en = 0; pe_en = 0;
        tick(2);

        // ---- engine busy held after done
        clear_rec();
        start_layer(8'd2);
        wait_start("tail_start0");
        check("tail_bank0", 32'(bus.wr_bank_sel), 32'd0);
        tick();
        check("tail_start_held", 32'(bus.start_ker_write), 32'd1);
        bus.ker_write_busy = 1'b1;
        tick();
        check("tail_start_ack", 32'(bus.start_ker_write), 32'd0);
        tick(5);
        bus.ker_write_done = 1'b1;
        tick();
        bus.ker_write_done = 1'b0;
        check("tail_valid0", 32'({bus.ker_bank_valid, bus.ker_bank_sel}), 32'b10);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("tail_start_low", 32'(bus.start_ker_write), 32'd0);
        end
        bus.ker_write_busy = 1'b0;
        tick();
        check("tail_start1", 32'({bus.start_ker_write, bus.wr_bank_sel}), 32'b11);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("tail_start1_hold", 32'(bus.start_ker_write), 32'd1);
        end
        bus.ker_write_busy = 1'b1;
        tick();
        check("tail_start1_ack", 32'(bus.start_ker_write), 32'd0);
        tick(3);
        pulse_done();
        pulse_comp();
        check("tail_comp0", 32'({bus.ker_bank_sel, bus.ker_bank_valid, bus.layer_done}), 32'b110);
        pulse_comp();
        check("tail_layer_done", 32'({bus.layer_done, bus.sched_busy}), 32'b10);
        tick();
        check("tail_done_width", 32'(bus.layer_done), 32'd0);

        // ---- ignored inputs
        clear_rec();
        start_layer(8'd2);
        wait_start("ign_start");
        pulse_comp();
        check("ign_comp_rd_cnt", 32'(dut.rd_cnt), 32'd0);
        check("ign_comp_rd_ptr", 32'(bus.ker_bank_sel), 32'd0);
        start_layer(8'd5);
        check("ign_restart_grp", 32'(dut.grp_num), 32'd2);
        bus.ker_write_busy = 1'b1;
        tick(3);
        pulse_done();
        eng_lat = 5; comp_lat = 3; eng_en = 1; pe_en = 1;
        wait_done("ign_layer_done", 300);
        check("ign_starts", 32'(start_cnt), 32'd2);
        check("ign_comps", 32'(comp_cnt), 32'd2);
        eng_en = 0; pe_en = 0;
        tick(3);

        // ---- zero groups
        clear_rec();
        start_layer(8'd0);
        check("g0_busy", 32'(bus.sched_busy), 32'd1);
        tick();
        check("g0_done", 32'({bus.layer_done, bus.sched_busy}), 32'b10);
        tick();
        check("g0_done_width", 32'(bus.layer_done), 32'd0);
        tick(3);
        check("g0_no_start", 32'(start_cnt), 32'd0);

        // ---- simultaneous write done (bank 1) and consume (bank 0)
        clear_rec();
        start_layer(8'd3);
        wait_start("sim_start0");
        bus.ker_write_busy = 1'b1;
        tick(3);
        pulse_done();
        wait_start("sim_start1");
        bus.ker_write_busy = 1'b1;
        tick(3);
        bus.ker_write_done = 1'b1;
        bus.comp_done = 1'b1;
        tick();
        bus.ker_write_done = 1'b0;
        bus.comp_done = 1'b0;
        bus.ker_write_busy = 1'b0;
        check("sim_bank_full", 32'(dut.bank_full), 32'b10);
        check("sim_rd_bank", 32'({bus.ker_bank_sel, bus.ker_bank_valid}), 32'b11);
        wait_start("sim_start2");
        check("sim_third_bank", 32'(bus.wr_bank_sel), 32'd0);
        bus.ker_write_busy = 1'b1;
        tick();
        pulse_done();
        pulse_comp();
        check("sim_not_done", 32'(bus.layer_done), 32'd0);
        pulse_comp();
        check("sim_layer_done", 32'(bus.layer_done), 32'd1);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ker_bank_sched.md
# ker_bank_sched

Ping-pong scheduler for the two kernel SRAM banks of one layer. It sequences the kernel write engine (start/busy/done handshake) and the PE compute side, so that group g+1 loads into one bank while group g is consumed from the other. It sits between the layer controller and the kernel write engine / PE array, and drives the bank-select lines used by the top level to steer SRAM enables.

## Interface
- GRP_BITS, 8: width of the kernel-group count; one group is 8 kernels, i.e. one full write-engine pass.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- layer_start  in  1  single-cycle pulse; a new layer is accepted only while sched_busy=0.
- cfg_grp_num  in  GRP_BITS  number of groups in the layer; sampled with an accepted layer_start.
- start_ker_write  out  1  start request to the write engine.
- ker_write_busy  in  1  write-engine busy level.
- ker_write_done  in  1  write-engine done pulse.
- wr_bank_sel  out  1  bank the write engine targets (= wr_ptr).
- ker_bank_sel  out  1  bank the PE array reads (= rd_ptr).
- ker_bank_valid  out  1  bank ker_bank_sel holds a complete group.
- comp_done  in  1  pulse: PE array finished the group in ker_bank_sel.
- sched_busy  out  1  layer in progress.
- layer_done  out  1  one-cycle pulse after the last group is consumed.

## Operation
- State: bank_full[1:0], wr_ptr, rd_ptr, wr_cnt, rd_cnt (GRP_BITS each), grp_num latch, write FSM.
- Write FSM states: WS_IDLE, WS_WAIT, WS_START, WS_RUN.
  - WS_IDLE: on accepted layer_start, latch grp_num, clear counters/pointers/bank_full, sched_busy<=1, go WS_WAIT.
  - WS_WAIT: if wr_cnt==grp_num, stay (writes finished). Otherwise, if bank_full[wr_ptr]==0 and ker_write_busy==0, go WS_START.
  - WS_START: start_ker_write=1, held until ker_write_busy is sampled 1, then go WS_RUN. This is a level handshake, so a start is never lost during the engine's post-done recovery cycles.
  - WS_RUN: on ker_write_done, set bank_full[wr_ptr], toggle wr_ptr, increment wr_cnt, go WS_WAIT.
- Read side, combinational from flops: ker_bank_valid = sched_busy & bank_full[rd_ptr].
  - comp_done with ker_bank_valid=1: clear bank_full[rd_ptr], toggle rd_ptr, increment rd_cnt.
  - comp_done with ker_bank_valid=0 is ignored.
- Completion: when rd_cnt reaches grp_num, pulse layer_done for one cycle, sched_busy<=0, write FSM to WS_IDLE.
- cfg_grp_num=0: no start issued; layer_done pulses on the cycle after acceptance.
- A set (write done) and a clear (comp_done) in the same cycle always hit different banks and both take effect.
- layer_start while sched_busy=1 is ignored.
- Counter widths are GRP_BITS; the maximum layer is 2^GRP_BITS-1 groups.

## Timing
- Reset values: start_ker_write=0, wr_bank_sel=0, ker_bank_sel=0, ker_bank_valid=0, sched_busy=0, layer_done=0. All state clears asynchronously.
- Reset mid-layer aborts immediately. The engine is not notified; the top level resets it in the same domain.
- Accepted layer_start at edge N:
  - sched_busy high after N.
  - start_ker_write high after N+1 (if ker_write_busy=0).
- ker_write_done sampled at edge M: ker_bank_valid rises after M when that bank is the read bank.
- Next start_ker_write: earliest after M+1, and only after ker_write_busy falls.
- comp_done at edge C:
  - ker_bank_sel toggles after C.
  - The freed bank becomes eligible for writing in WS_WAIT at C+1.
- layer_done: registered, high for exactly one cycle after the edge where the final comp_done is sampled.

## Structure
- Shared package ker_sched_pkg holds the write-FSM state encodings (2-bit) and the GRP_BITS default.
- No sub-module; the group counters are inline because the async active-low reset differs from the shared counter's reset.

## Test plan
- Reset mid-layer (reset low during WS_RUN) -> all outputs return to their reset values asynchronously; a new layer_start is then accepted.
- cfg_grp_num=1, engine done 300 cycles after busy, comp_done 20 cycles after valid:
  - one start_ker_write, wr_bank_sel=0;
  - ker_bank_valid high on bank 0;
  - layer_done 1 cycle after comp_done.
- cfg_grp_num=4, slow compute (comp_done 1000 cycles after valid):
  - starts alternate banks 0,1;
  - the third start is held until the first comp_done frees bank 0;
  - 4 starts total, layer_done after the 4th comp_done.
- Engine busy held high 3 cycles after done -> start_ker_write stays low until busy=0, then holds high until busy=1.
- Ignored inputs:
  - comp_done while ker_bank_valid=0 -> rd_cnt unchanged;
  - layer_start while busy -> grp_num unchanged;
  - cfg_grp_num=0 -> no start, layer_done after 1 cycle.
- Simultaneous ker_write_done on bank 1 and comp_done on bank 0 (cfg_grp_num=3) -> bank_full becomes 2'b10, ker_bank_sel=1, the third write targets bank 0.
